// File: rtl/riscv_pkg.sv
// Shared pipeline constants: datapath sizes, stage indices, per-op-class result latencies.
package riscv_pkg;

  localparam int RV_XLEN = 32;
  localparam int RV_AW   = 5;

  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Latency codes that name no real stage are treated as "ready only at writeback".
  function automatic int norm_lat(input int lat, input int depth);
    return (lat < 1 || lat > depth) ? depth : lat;
  endfunction

endpackage

// File: rtl/fwd_port_mux.sv
// Per-read-port bypass select: youngest matching in-flight write wins; zero-latency combinational.
// Flags need_stall_o when that youngest producer has not yet reached its result-ready stage.
module fwd_port_mux #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int LW    = 2,
  parameter int SW    = 2
) (
  input  logic [DEPTH-1:0]      ent_v_i,
  input  logic [DEPTH*AW-1:0]   ent_rd_i,
  input  logic [DEPTH*LW-1:0]   ent_lat_i,
  input  logic [AW-1:0]         src_addr_i,
  input  logic [XLEN-1:0]       src_rdata_i,
  input  logic [DEPTH*XLEN-1:0] stage_result_i,
  output logic [SW-1:0]         fwd_sel_o,
  output logic [XLEN-1:0]       opnd_o,
  output logic                  need_stall_o
);

  // Walk from oldest to youngest so the last hit (lowest stage) wins.
  always_comb begin
    fwd_sel_o    = '0;
    opnd_o       = src_rdata_i;
    need_stall_o = 1'b0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (ent_v_i[s-1] && (ent_rd_i[(s-1)*AW +: AW] == src_addr_i) && (src_addr_i != '0)) begin
        fwd_sel_o    = SW'(s);
        opnd_o       = stage_result_i[(s-1)*XLEN +: XLEN];
        need_stall_o = (s < int'(ent_lat_i[(s-1)*LW +: LW]));
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard: shifts in-flight writes through DEPTH stages, zero-latency bypass and stall.
// Issue backpressure is the stall output; hold freezes the pipeline, flush squashes the stage-1 slot.
module fwd_scoreboard
  import riscv_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int AW    = RV_AW,
  parameter int NRD   = 2,
  parameter int DEPTH = 3,
  parameter int LW    = 2,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [AW-1:0]         issue_rd,
  input  logic [LW-1:0]         issue_lat,
  input  logic [NRD*AW-1:0]     src_addr,
  input  logic [NRD*XLEN-1:0]   src_rdata,
  input  logic [DEPTH*XLEN-1:0] stage_result,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall,
  output logic [NRD*SW-1:0]     fwd_sel,
  output logic [NRD*XLEN-1:0]   opnd,
  output logic [31:0]           stall_cnt
);

  logic [DEPTH-1:0]    v_q, v_d;
  logic [DEPTH*AW-1:0] rd_q, rd_d;
  logic [DEPTH*LW-1:0] lat_q, lat_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  logic [NRD-1:0]      need_stall;
  logic                issue_fire;
  logic [LW-1:0]       lat_norm;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    fwd_port_mux #(
      .XLEN (XLEN),
      .AW   (AW),
      .DEPTH(DEPTH),
      .LW   (LW),
      .SW   (SW)
    ) u_mux (
      .ent_v_i       (v_q),
      .ent_rd_i      (rd_q),
      .ent_lat_i     (lat_q),
      .src_addr_i    (src_addr[i*AW +: AW]),
      .src_rdata_i   (src_rdata[i*XLEN +: XLEN]),
      .stage_result_i(stage_result),
      .fwd_sel_o     (fwd_sel[i*SW +: SW]),
      .opnd_o        (opnd[i*XLEN +: XLEN]),
      .need_stall_o  (need_stall[i])
    );
  end

  assign stall      = issue_valid & (|need_stall);
  assign issue_fire = issue_valid & ~stall & ~hold & ~flush;
  assign lat_norm   = LW'(norm_lat(int'(issue_lat), DEPTH));
  assign stall_cnt  = stall_cnt_q;

  always_comb begin
    v_d   = v_q;
    rd_d  = rd_q;
    lat_d = lat_q;
    if (!hold) begin
      v_d[0]        = issue_fire & issue_we & (issue_rd != '0);
      rd_d[0 +: AW] = issue_rd;
      lat_d[0 +: LW] = lat_norm;
      for (int s = 1; s < DEPTH; s++) begin
        v_d[s]             = v_q[s-1];
        rd_d[s*AW +: AW]   = rd_q[(s-1)*AW +: AW];
        lat_d[s*LW +: LW]  = lat_q[(s-1)*LW +: LW];
      end
    end
    // The squashed stage-1 instruction must not surface in stage 2, held or not.
    if (flush) begin
      for (int s = 0; s < 2 && s < DEPTH; s++) begin
        v_d[s] = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !hold && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= '0;
      rd_q        <= '0;
      lat_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      rd_q        <= rd_d;
      lat_q       <= lat_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
Parametrised hazard and forwarding unit for the in-order RISC-V pipeline, replacing the fixed E/M/W hazard logic. It tracks in-flight register writes through DEPTH post-issue stages, each write with its own result-ready stage (ALU, load, multi-cycle ops). It drives per-read-port bypass selects and operands, a single issue stall, and a saturating stall counter. It sits between decode/issue, the register file read ports and the per-stage result buses.

Parameters:
XLEN, 32, datapath width
AW, 5, register address width (2**AW registers; x0 hardwired zero)
NRD, 2, number of source read ports at issue
DEPTH, 3, post-issue stages tracked (stage 1 = execute … DEPTH = writeback)
LW, 2, width of latency field; must hold values 1..DEPTH
SW, clog2(DEPTH+1), width of one forward select

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  instruction present at issue
issue_we  in  1  issuing instruction writes rd
issue_rd  in  AW  destination register
issue_lat  in  LW  stage (1..DEPTH) at which the result first appears on stage_result
src_addr  in  NRD*AW  source register addresses, port i at [i*AW +: AW]
src_rdata  in  NRD*XLEN  register file read data
stage_result  in  DEPTH*XLEN  result of stage s at [(s-1)*XLEN +: XLEN]
hold  in  1  global freeze (memory wait)
flush  in  1  squash issuing instruction and stage-1 entry
stall  out  1  issue must not advance
fwd_sel  out  NRD*SW  per port: 0 = register file, s = stage s
opnd  out  NRD*XLEN  forwarded operand per port
stall_cnt  out  32  saturating count of hazard-stall cycles

Behaviour:
- State: entry[1..DEPTH], each {v, rd, lat}. Stage s is ready when s >= lat.
- Reset (synchronous, priority over all): all entry.v=0, stall_cnt=0. Outputs then: stall=0, fwd_sel=0, opnd=src_rdata.
- Match for port i at stage s: entry[s].v & entry[s].rd==src_addr_i & src_addr_i!=0. The lowest s wins (youngest producer).
- fwd_sel_i = winning s, or 0 if there is no match. opnd_i = stage_result[s] or src_rdata_i. Both are purely combinational with zero latency.
- stall = issue_valid & OR over ports of (match exists & winning stage not ready). An older ready match never overrides a younger unready one.
- issue_fire = issue_valid & ~stall & ~hold & ~flush.
- Clock edge, hold=0:
  - entry[1] <= issue_fire ? {issue_we & issue_rd!=0, issue_rd, issue_lat} : bubble (v=0).
  - entry[s] <= entry[s-1] for s>=2.
  - entry[DEPTH] retires.
- hold=1: all entries keep their values; stall is still evaluated.
- flush=1: entry[1] <= bubble and entry[2] <= bubble (the squashed stage-1 instruction does not advance). This applies even when hold=1. Under hold, entries 3..DEPTH stay frozen; otherwise they shift normally.
- issue_lat outside 1..DEPTH is treated as DEPTH. issue_we=0 or rd=x0 inserts an invalid entry.
- stall_cnt increments when stall & ~hold & ~flush, and saturates at 0xFFFF_FFFF.
- Stage DEPTH must be forwarded, because the register file writes on the clock edge and reads old data in the same cycle.

Decomposition:
- Shared package (riscv_pkg): XLEN, register address width, stage index constants (STG_EX=1, STG_MEM=2, STG_WB=3), and latency codes per op class (LAT_ALU=1, LAT_LOAD=2).
- Sub-module fwd_port_mux: one instance per read port, generated NRD times. Inputs are entries, src_addr, src_rdata and stage_result. Outputs are fwd_sel, opnd and need_stall. The top level holds the entry shift pipeline, the stall OR-reduction and stall_cnt.

Test Plan (DEPTH=3, NRD=2):
1. Reset mid-operation: fill entries with rd=5,6,7, then assert reset one cycle. Next cycle with src0=5: stall=0, fwd_sel0=0, opnd0=src_rdata0, stall_cnt=0.
2. ALU back-to-back: issue rd=5, lat=1. Next cycle src0=5 with stage_result[1]=0x1234: fwd_sel0=1, opnd0=0x1234, stall=0.
3. Load-use: issue rd=7, lat=2. Next cycle src1=7: stall=1 and stall_cnt becomes 1. Following cycle: stall=0, fwd_sel1=2, opnd1=stage_result[2].
4. Priority/x0: issue rd=3 (lat=1) twice. src0=src1=3 gives fwd_sel=1 on both ports, not 2. Issue rd=0 or we=0, rd=9: later reads of x0 and x9 give fwd_sel=0 and stall=0.
5. Hold: issue rd=4, lat=3. Next cycle hold=1 for 2 cycles with src0=4: stall=1 throughout, stall_cnt unchanged, entries frozen. After release, the stall clears once the entry reaches stage 3, with fwd_sel0=3.
6. Flush: issue rd=8, lat=2, then assert flush with src0=8 and issue_valid=1. The next cycle has no match on 8 (fwd_sel0=0, stall=0), and the flushed issue did not enter entry[1].
